// File: rtl/mux_channel_scanner.sv
// Scans a 16:1 analog/digital mux: steps the select through all channels,
// waits SETTLE_CYC cycles per channel, samples y_in and publishes a 16-bit word.
module mux_channel_scanner #(
  parameter int SETTLE_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        y_in,
  output logic [3:0]  sel,
  output logic [15:0] data,
  output logic        valid,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_t      state, state_n;
  logic [3:0]  sel_n;
  logic [3:0]  cnt, cnt_n;
  logic [15:0] cap, cap_n;
  logic [15:0] data_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= 4'd0;
      cnt   <= 4'd0;
      cap   <= 16'h0000;
      data  <= 16'h0000;
    end else begin
      state <= state_n;
      sel   <= sel_n;
      cnt   <= cnt_n;
      cap   <= cap_n;
      data  <= data_n;
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = sel;
    cnt_n   = cnt;
    cap_n   = cap;
    data_n  = data;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          sel_n   = 4'd0;
          cnt_n   = 4'd0;
          cap_n   = 16'h0000;
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        if (abort) begin
          sel_n   = 4'd0;
          cnt_n   = 4'd0;
          cap_n   = 16'h0000;
          state_n = IDLE;
        end else if (cnt == SETTLE_LAST) begin
          cnt_n   = 4'd0;
          state_n = SAMPLE;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      SAMPLE: begin
        if (abort) begin
          sel_n   = 4'd0;
          cnt_n   = 4'd0;
          cap_n   = 16'h0000;
          state_n = IDLE;
        end else begin
          cap_n[sel] = y_in;
          cnt_n      = 4'd0;
          // Last channel publishes the word including the bit just sampled.
          if (sel == 4'd15) begin
            data_n  = cap_n;
            state_n = DONE;
          end else begin
            sel_n   = sel + 4'd1;
            state_n = SETTLE;
          end
        end
      end
      DONE: begin
        sel_n   = 4'd0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy  = (state == SETTLE) || (state == SAMPLE);
  assign valid = (state == DONE);

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Randomized scoreboard bench: two scanners (SETTLE_CYC=2 and 1) share control
// inputs; a per-scan reference derived from cycle arithmetic predicts outputs.
module tb_mux_channel_scanner;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [1:0][15:0]  v;
  logic [1:0]        y;
  logic [1:0][3:0]   sel_a;
  logic [1:0][15:0]  data_a;
  logic [1:0]        valid_a, busy_a;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        q0[$], q1[$];
  exp_t        e_m, e_p;
  int          k[2] = '{-1, -1};
  logic [15:0] ldata[2] = '{16'h0000, 16'h0000};
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign y[0] = v[0][sel_a[0]];
  assign y[1] = v[1][sel_a[1]];

  mux_channel_scanner #(.SETTLE_CYC(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .y_in(y[0]),
    .sel(sel_a[0]), .data(data_a[0]), .valid(valid_a[0]), .busy(busy_a[0])
  );

  mux_channel_scanner #(.SETTLE_CYC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .y_in(y[1]),
    .sel(sel_a[1]), .data(data_a[1]), .valid(valid_a[1]), .busy(busy_a[1])
  );

  function automatic int sc(int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic int len(int d);
    return 16 * (sc(d) + 1);
  endfunction

  // k = edges since the accept edge; -1 means idle.
  function automatic int esel(int d);
    if (k[d] < 0) return 0;
    if (k[d] < len(d)) return k[d] / (sc(d) + 1);
    return 15;
  endfunction

  task automatic chk(string nm, int d, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h", nm, d, cyc, act, exp);
    end
  endtask

  // Reference model: advances once per rising edge from the sampled controls.
  always @(posedge clk) begin
    if (rst_n) begin
      cyc++;
      for (int d = 0; d < 2; d++) begin
        if (k[d] == -1) begin
          if (start && !abort) begin
            k[d] = 0;
            e_m.data = v[d];
            e_m.due  = cyc + len(d);
            if (d == 0) q0.push_back(e_m); else q1.push_back(e_m);
          end
        end else if (k[d] < len(d)) begin
          if (abort) begin
            k[d] = -1;
            if (d == 0) void'(q0.pop_back()); else void'(q1.pop_back());
          end else begin
            k[d]++;
            if (k[d] == len(d)) ldata[d] = v[d];
          end
        end else begin
          k[d] = -1;
        end
      end
    end
  end

  always @(negedge rst_n) begin
    k = '{-1, -1};
    q0.delete();
    q1.delete();
    ldata = '{16'h0000, 16'h0000};
  end

  // Monitor: per-cycle output checks plus scoreboard pop on every valid pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        chk("sel", d, sel_a[d], esel(d));
        chk("busy", d, busy_a[d], (k[d] >= 0 && k[d] < len(d)) ? 1 : 0);
        chk("valid", d, valid_a[d], (k[d] == len(d)) ? 1 : 0);
        chk("data_hold", d, data_a[d], ldata[d]);
        if (valid_a[d]) begin
          if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            chk("unexpected_valid", d, 1, 0);
          end else begin
            e_p = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk("scan_data", d, data_a[d], e_p.data);
            chk("scan_latency", d, cyc, e_p.due);
          end
        end
      end
    end
  end

  task automatic wait_k(int target);
    for (int n = 0; n < 400 && k[0] != target; n++) @(negedge clk);
    if (k[0] != target) chk("wait_timeout", 0, k[0], target);
  endtask

  initial begin
    v[0] = 16'h5A5A;
    v[1] = 16'hFFFF;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_sel", d, sel_a[d], 0);
      chk("rst_data", d, data_a[d], 0);
      chk("rst_busy", d, busy_a[d], 0);
      chk("rst_valid", d, valid_a[d], 0);
    end
    // Start on the first edge after reset release.
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (60) @(negedge clk);

    // Held start: back-to-back scans with one idle cycle between.
    start = 1'b1;
    repeat (200) @(negedge clk);
    start = 1'b0;
    repeat (60) @(negedge clk);

    // Abort at sel=7, first SETTLE cycle.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_k(21);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (60) @(negedge clk);

    // Start and abort together in idle.
    start = 1'b1;
    abort = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);

    // Asynchronous reset mid-scan at sel=10.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_k(31);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("async_sel", d, sel_a[d], 0);
      chk("async_data", d, data_a[d], 0);
      chk("async_busy", d, busy_a[d], 0);
      chk("async_valid", d, valid_a[d], 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Randomized control and mux contents.
    for (int n = 0; n < 1500; n++) begin
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 40) == 0);
      if (k[0] == -1) v[0] = 16'($urandom);
      if (k[1] == -1) v[1] = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (60) @(negedge clk);
    chk("leftover", 0, q0.size(), 0);
    chk("leftover", 1, q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
